// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer: state encoding, halt opcode default
// and stage-index constants used by the datapath top.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EXE  = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  localparam logic [6:0] HALT_OPCODE_DEF = 7'h73;

  localparam int STAGE_IF   = 0;
  localparam int STAGE_ID   = 1;
  localparam int STAGE_EXE  = 2;
  localparam int STAGE_MEM  = 3;
  localparam int STAGE_WB   = 4;
  localparam int NUM_STAGES = 5;

  // One-hot stage enables; IDLE and HALT map to all-zero.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_e s);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    case (s)
      ST_IF:   v[STAGE_IF]  = 1'b1;
      ST_ID:   v[STAGE_ID]  = 1'b1;
      ST_EXE:  v[STAGE_EXE] = 1'b1;
      ST_MEM:  v[STAGE_MEM] = 1'b1;
      ST_WB:   v[STAGE_WB]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
// Instantiated by stage_sequencer only when PERF_COUNTERS_EN is defined.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking for sequential state so all flops update from pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EXE/MEM/WB stage controller with halt and protocol-error tracking.
// Optional performance counters are built only when PERF_COUNTERS_EN is defined.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter logic [6:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             branch,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             state_if,
  output logic             state_id,
  output logic             state_exe,
  output logic             state_mem,
  output logic             state_wb,
  output logic             branch_taken,
  output logic             instr_done,
  output logic             halted,
  output logic             proto_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e                state_q, state_d;
  logic                  proto_err_q, proto_err_d;
  logic                  retire;
  logic [NUM_STAGES-1:0] stage_en;

  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    retire      = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_IF;
      ST_IF:   state_d = ST_ID;
      ST_ID:   state_d = (opcode == HALT_OPCODE) ? ST_HALT : ST_EXE;
      ST_EXE: begin
        if (mem_read && mem_write) proto_err_d = 1'b1;
        if (mem_read || mem_write) state_d = ST_MEM;
        else if (reg_write)        state_d = ST_WB;
        else                       retire  = 1'b1;
      end
      ST_MEM: begin
        if (dm_ready) begin
          if (reg_write) state_d = ST_WB;
          else           retire  = 1'b1;
        end
      end
      ST_WB:   retire  = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // An instruction always finishes; run only decides whether another one follows.
    if (retire) state_d = run ? ST_IF : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign stage_en     = stage_onehot(state_q);
  assign state_if     = stage_en[STAGE_IF];
  assign state_id     = stage_en[STAGE_ID];
  assign state_exe    = stage_en[STAGE_EXE];
  assign state_mem    = stage_en[STAGE_MEM];
  assign state_wb     = stage_en[STAGE_WB];
  assign branch_taken = branch & zero & state_exe;
  assign instr_done   = retire;
  assign halted       = (state_q == ST_HALT);
  assign proto_err    = proto_err_q;

`ifdef PERF_COUNTERS_EN
  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (|stage_en),
    .cnt   (cycle_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .cnt   (retired_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule
